alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: MULDIV_WAIT, default 2, extra wait cycles before capturing the result of a multiply (op 100) or divide (op 101).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester n presents an operation.
REQ-006 req0_ready, req1_ready  output  1 each  operation of requester n is accepted this cycle.
REQ-007 req0_op, req1_op  input  3 each  ALU operation code.
- 000 add, 001 sub, 010 and, 011 or, 100 mul, 101 div; 110 and 111 are illegal.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  16 each  operands.
REQ-009 alu_a, alu_b  output  16 each  operands driven to the shared ALU.
REQ-010 alu_ctrl  output  3  ALUControl driven to the shared ALU.
REQ-011 alu_result  input  16  Result returned by the shared ALU (combinational).
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumer accepts.
REQ-014 rsp_id  output  1  requester index of the response.
REQ-015 rsp_data  output  16  result.
REQ-016 rsp_err  output  1  error flag (illegal op or divide by zero).
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have four states, encoded internally:
- IDLE: wait for a request.
- EXEC: ALU evaluates the captured operands.
- WAIT: multicycle hold for mul/div.
- RESP: response held for the consumer.
REQ-019 Ready rule: in IDLE, reqN_ready SHALL be high combinationally only for the granted requester, only when its valid is high.
- At most one ready is high per cycle.
- Both readies are low in all other states.
REQ-020 Grant rule:
- A single valid requester is granted.
- If both are valid, the requester other than last_grant is granted.
- last_grant updates on every handshake.
REQ-021 On a handshake the block SHALL register op, a, b and the requester id, then move to EXEC.
REQ-022 alu_a, alu_b and alu_ctrl SHALL be driven only from the registered operands and op, never directly from requester inputs.
REQ-023 Simple ops (000-011) SHALL follow this path:
- In EXEC, register alu_result into rsp_data with rsp_err=0, then go to RESP.
- Handshake at cycle N gives rsp_valid high from cycle N+2.
REQ-024 Mul/div SHALL follow this path:
- EXEC goes to WAIT, where a counter runs MULDIV_WAIT cycles.
- alu_result is captured at the end of the last WAIT cycle; rsp_valid rises at cycle N+2+MULDIV_WAIT.
- With MULDIV_WAIT=0, EXEC captures directly, as for simple ops.
REQ-025 Divide by zero (op 101 with registered b==0): in EXEC the block SHALL set rsp_data=16'hFFFF and rsp_err=1, and go to RESP without WAIT; rsp_valid rises at N+2.
REQ-026 Illegal op (110/111): in EXEC the block SHALL set rsp_data=16'h0000 and rsp_err=1, and go to RESP; rsp_valid rises at N+2.
REQ-027 Width rule: results SHALL be the low 16 bits returned by the ALU, with no overflow or carry flag.
REQ-028 Response hold: in RESP, rsp_valid, rsp_id, rsp_data and rsp_err SHALL stay stable until rsp_valid and rsp_ready are both high; the FSM then returns to IDLE.
REQ-029 rsp_valid SHALL fall in the cycle after the response handshake.
REQ-030 Throughput: a new request SHALL NOT be accepted in the same cycle as a response handshake; acceptance occurs from the following IDLE cycle.
REQ-031 Requests arriving while busy SHALL be held off (ready low) and SHALL NOT be dropped; the requester keeps valid high.

Reset
REQ-032 While rst is high, all outputs SHALL be 0:
- rsp_valid, rsp_data, rsp_id, rsp_err, alu_a, alu_b, alu_ctrl, busy, and both readies.
- State = IDLE, WAIT counter = 0, last_grant = 1 (requester 0 wins the first tie).
REQ-033 Reset asserted mid-operation (EXEC, WAIT or RESP) SHALL abandon the transaction with no response emitted.
REQ-034 The first handshake SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-035 Add: req0 op=000, a=16'h1234, b=16'h0001, rsp_ready=1 -> rsp_valid at N+2 with rsp_data=16'h1235, rsp_id=0, rsp_err=0.
REQ-036 Tie: both valid from reset; req0 sub 5-7, req1 and F0F0&0FF0 -> first rsp_id=0, data=16'hFFFE; second rsp_id=1, data=16'h00F0.
REQ-037 Multiply, MULDIV_WAIT=2: mul 16'h0100*16'h0100 -> rsp_valid at N+4, data=16'h0000 (truncated), err=0.
- div 100/7 -> data=16'd14.
REQ-038 Errors: div 50/0 -> data=16'hFFFF, err=1 at N+2; op 111 -> data=0, err=1.
REQ-039 Backpressure: rsp_ready held low 5 cycles with req1 valid -> response stable, req1_ready low throughout; req1 accepted one cycle after the response handshake.
REQ-040 Reset in WAIT: assert rst during WAIT of a div -> no rsp_valid pulse; after release, tie goes to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: grants one requester at a time,
// sequences the operation (with extra hold cycles for mul/div) and presents a held response.
module alu_arbiter #(
  parameter int MULDIV_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  localparam int CW = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (MULDIV_WAIT > 0) ? CW'(MULDIV_WAIT - 1) : '0;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [15:0]   a_q, a_d;
  logic [15:0]   b_q, b_d;
  logic          id_q, id_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   data_q, data_d;
  logic          err_q, err_d;
  logic          grant_id;

  // On a tie the requester that did not win last time gets the slot.
  assign grant_id = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          op_d         = req1_ready ? req1_op : req0_op;
          a_d          = req1_ready ? req1_a  : req0_a;
          b_d          = req1_ready ? req1_b  : req0_b;
          id_d         = req1_ready;
          last_grant_d = req1_ready;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        cnt_d = '0;
        if (op_q[2:1] == 2'b11) begin
          data_d  = 16'h0000;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (op_q == 3'b101 && b_q == 16'h0000) begin
          data_d  = 16'hFFFF;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (op_q[2] && MULDIV_WAIT > 0) begin
          state_d = WAIT;
        end else begin
          data_d  = alu_result;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          data_d  = alu_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Readies are gated by rst so they read low even while requesters hold valid in reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && state_q == IDLE) begin
      req0_ready = req0_valid && !grant_id;
      req1_ready = req1_valid && grant_id;
    end
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
    rsp_id    = id_q;
    rsp_data  = data_q;
    rsp_err   = err_q;
    alu_a     = a_q;
    alu_b     = b_q;
    alu_ctrl  = op_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written corner sequences and
// randomized transactions checked against an arithmetic reference model.
module tb_alu_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op, alu_ctrl;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] alu_a, alu_b, alu_result, rsp_data;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int last_hs_cyc = 0;
  int rsp_hs_cyc = 0;
  logic tb_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.MULDIV_WAIT(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  // Shared combinational ALU seen by the arbiter.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a * alu_b;
      3'b101:  alu_result = (alu_b == 16'h0) ? 16'h0 : alu_a / alu_b;
      default: alu_result = 16'h0;
    endcase
  end

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        e;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", what, act, exp);
    end
  endtask

  task automatic fail_timeout(input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", what);
  endtask

  // Expected response computed from the operation rules with wide integer arithmetic.
  function automatic void ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] d, output logic e, output int lat);
    longint x;
    longint y;
    x = longint'(a);
    y = longint'(b);
    e = 1'b0;
    lat = 2;
    d = 16'h0;
    case (op)
      3'd0: d = 16'((x + y) % 65536);
      3'd1: d = 16'((x - y + 65536) % 65536);
      3'd2: d = a & b;
      3'd3: d = a | b;
      3'd4: begin d = 16'((x * y) % 65536); lat = 2 + W; end
      3'd5: begin
        if (y == 0) begin d = 16'hFFFF; e = 1'b1; end
        else begin d = 16'(x / y); lat = 2 + W; end
      end
      default: begin d = 16'h0; e = 1'b1; end
    endcase
  endfunction

  task automatic set_req(input logic n, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (n) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else   begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {25'b0, rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready, alu_ctrl}, 32'h0);
    chk({tag, "_data"}, {rsp_data, alu_a}, 32'h0);
    chk({tag, "_alub"}, {16'h0, alu_b}, 32'h0);
  endtask

  // One request/response transaction; holds rsp_ready low for 'hold' cycles of RESP.
  task automatic run_one(input int hold, output logic gid, output logic rid, output logic [15:0] gd,
                         output logic ge, output int glat);
    int i;
    int n_hs;
    logic sid;
    logic se;
    logic [15:0] sd;
    gid = 1'b0; rid = 1'b0; gd = 16'h0; ge = 1'b0; glat = -1;
    #1;
    i = 0;
    while (!(req0_ready || req1_ready) && i < 40) begin @(negedge clk); i++; end
    if (!(req0_ready || req1_ready)) begin fail_timeout("grant_wait"); return; end
    chk("single_ready", {31'b0, req0_ready & req1_ready}, 32'h0);
    gid = req1_ready;
    n_hs = cyc;
    last_hs_cyc = cyc;
    @(posedge clk); #1;
    if (gid) req1_valid = 1'b0; else req0_valid = 1'b0;
    i = 0;
    while (!rsp_valid && i < 40) begin @(negedge clk); i++; end
    if (!rsp_valid) begin fail_timeout("rsp_wait"); return; end
    glat = cyc - n_hs;
    rid = rsp_id; gd = rsp_data; ge = rsp_err;
    sid = rsp_id; sd = rsp_data; se = rsp_err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_stable", {11'b0, rsp_valid, rsp_id, rsp_err, rsp_data, req0_ready, req1_ready},
          {11'b0, 1'b1, sid, se, sd, 2'b00});
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_ready_low", {30'b0, req0_ready, req1_ready}, 32'h0);
    rsp_hs_cyc = cyc;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'h0);
    $display("txn cyc=%0d id=%0d data=%h err=%0d lat=%0d", n_hs, rid, gd, ge, glat);
  endtask

  task automatic cmp(input string tag, input logic gid, input logic rid, input logic [15:0] gd,
                     input logic ge, input int glat, input logic eid, input logic [15:0] ed,
                     input logic ee, input int elat);
    chk({tag, "_grant"}, {31'b0, gid}, {31'b0, eid});
    chk({tag, "_rsp_id"}, {31'b0, rid}, {31'b0, eid});
    chk({tag, "_data"}, {16'b0, gd}, {16'b0, ed});
    chk({tag, "_err"}, {31'b0, ge}, {31'b0, ee});
    chk({tag, "_lat"}, glat, elat);
  endtask

  task automatic model_txn(input logic eid, input int hold, input string tag);
    logic [15:0] ed, gd;
    logic ee, gid, rid, ge;
    int elat, glat;
    if (eid) ref_model(req1_op, req1_a, req1_b, ed, ee, elat);
    else     ref_model(req0_op, req0_a, req0_b, ed, ee, elat);
    run_one(hold, gid, rid, gd, ge, glat);
    cmp(tag, gid, rid, gd, ge, glat, eid, ed, ee, elat);
    tb_last = eid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gid, rid, ge, saw;
    logic [15:0] gd;
    int glat, i, bp_hs;

    tbl[0]  = '{1'b0, 3'd0, 16'h1234, 16'h0001, 16'h1235, 1'b0, 2};
    tbl[1]  = '{1'b1, 3'd4, 16'h0100, 16'h0100, 16'h0000, 1'b0, 4};
    tbl[2]  = '{1'b0, 3'd5, 16'd100,  16'd7,    16'd14,   1'b0, 4};
    tbl[3]  = '{1'b1, 3'd5, 16'd50,   16'd0,    16'hFFFF, 1'b1, 2};
    tbl[4]  = '{1'b0, 3'd7, 16'h1234, 16'h5678, 16'h0000, 1'b1, 2};
    tbl[5]  = '{1'b1, 3'd6, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 2};
    tbl[6]  = '{1'b0, 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 2};
    tbl[7]  = '{1'b1, 3'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 2};
    tbl[8]  = '{1'b0, 3'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 2};
    tbl[9]  = '{1'b1, 3'd4, 16'h0003, 16'h0005, 16'h000F, 1'b0, 4};
    tbl[10] = '{1'b0, 3'd5, 16'hFFFF, 16'h0100, 16'h00FF, 1'b0, 4};
    tbl[11] = '{1'b1, 3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 2};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    tb_last = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset_idle");

    // Tie from reset: both requesters valid while still in reset.
    set_req(1'b0, 3'd1, 16'd5, 16'd7);
    set_req(1'b1, 3'd2, 16'hF0F0, 16'h0FF0);
    #1;
    chk_reset_outs("reset_valid_held");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_edge_ready", {30'b0, req0_ready, req1_ready}, 32'h2);
    run_one(0, gid, rid, gd, ge, glat);
    cmp("tie_first", gid, rid, gd, ge, glat, 1'b0, 16'hFFFE, 1'b0, 2);
    run_one(0, gid, rid, gd, ge, glat);
    cmp("tie_second", gid, rid, gd, ge, glat, 1'b1, 16'h00F0, 1'b0, 2);
    tb_last = 1'b1;

    for (int v = 0; v < 12; v++) begin
      set_req(tbl[v].id, tbl[v].op, tbl[v].a, tbl[v].b);
      run_one(v % 3, gid, rid, gd, ge, glat);
      cmp($sformatf("tbl%0d", v), gid, rid, gd, ge, glat, tbl[v].id, tbl[v].d, tbl[v].e, tbl[v].lat);
      tb_last = tbl[v].id;
    end

    // Backpressure: the losing requester waits through a stalled response.
    set_req(1'b0, 3'd0, 16'h0001, 16'h0002);
    set_req(1'b1, 3'd1, 16'h0010, 16'h0003);
    model_txn(~tb_last, 5, "bp_first");
    bp_hs = rsp_hs_cyc;
    model_txn(~tb_last, 0, "bp_second");
    chk("bp_accept_cycle", last_hs_cyc, bp_hs + 1);

    // Reset while a divide sits in WAIT.
    set_req(1'b0, 3'd5, 16'd100, 16'd7);
    #1;
    i = 0;
    while (!req0_ready && i < 40) begin @(negedge clk); i++; end
    if (!req0_ready) fail_timeout("rstwait_grant");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("wait_busy", {30'b0, busy, rsp_valid}, 32'h2);
    rst = 1'b1;
    #1;
    chk_reset_outs("rst_mid");
    set_req(1'b0, 3'd0, 16'd7, 16'd8);
    set_req(1'b1, 3'd3, 16'h1200, 16'h0034);
    saw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      saw = saw | rsp_valid;
      chk_reset_outs("rst_hold");
    end
    rst = 1'b0;
    tb_last = 1'b1;
    #1;
    saw = saw | rsp_valid;
    chk("no_rsp_after_abort", {31'b0, saw}, 32'h0);
    model_txn(1'b0, 0, "post_rst_tie0");
    model_txn(1'b1, 1, "post_rst_tie1");

    for (int t = 0; t < 40; t++) begin
      logic [1:0] mask;
      logic first;
      mask = 2'($urandom_range(1, 3));
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      req0_a = 16'($urandom);
      req1_a = 16'($urandom);
      req0_b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      req1_b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      req0_valid = mask[0];
      req1_valid = mask[1];
      first = (mask == 2'b11) ? ~tb_last : mask[1];
      model_txn(first, int'($urandom_range(0, 3)), $sformatf("rnd%0d_a", t));
      if (mask == 2'b11) model_txn(~first, int'($urandom_range(0, 3)), $sformatf("rnd%0d_b", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
